// File: rtl/if_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | if_fetch : instruction-fetch stage (PC, req/ack fetch, prefetch FIFO)    |
// | Optional perf counters: define IF_PERF_CNT_EN. Revision: 1.0             |
// +--------------------------------------------------------------------------+
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          FB_DEPTH = 2
) (
  input  logic        clk,
  input  logic        clr_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] Instr,
  output logic [31:0] pc4,
  output logic        if_valid,
  output logic        flush
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt
`endif
);

  localparam int AW = $clog2(FB_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] c_fb_depth = CW'(FB_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t        r_state;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_addr;
  logic          r_req;

  logic [31:0]   r_fb_instr [FB_DEPTH];
  logic [31:0]   r_fb_pc4   [FB_DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;

  logic [31:0]   w_tgt;
  logic [31:0]   w_pc_plus4;
  logic          w_push;
  logic          w_pop;

  assign w_tgt      = redirect_pc & 32'hFFFF_FFFC;
  assign w_pc_plus4 = r_fetch_pc + 32'd4;

  assign if_valid  = (r_count != '0);
  assign Instr     = if_valid ? r_fb_instr[r_rd_ptr] : '0;
  assign pc4       = if_valid ? r_fb_pc4[r_rd_ptr]   : '0;
  assign flush     = redirect;
  assign imem_req  = r_req;
  assign imem_addr = r_addr;

  // Redirect beats both push and pop: it empties the FIFO on this edge.
  assign w_push = (r_state == S_REQ) & imem_ack & ~redirect;
  assign w_pop  = if_valid & ~stall & ~redirect;

  always_comb begin
    w_count_next = r_count;
    if (redirect)
      w_count_next = '0;
    else
      w_count_next = r_count + CW'(w_push) - CW'(w_pop);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_addr     <= RESET_PC;
      r_req      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (redirect) r_fetch_pc <= w_tgt;
          r_addr <= redirect ? w_tgt : r_fetch_pc;
          if (w_count_next < c_fb_depth) begin
            r_state <= S_REQ;
            r_req   <= 1'b1;
          end
        end
        S_REQ: begin
          if (imem_ack && redirect) begin
            r_fetch_pc <= w_tgt;
            r_addr     <= w_tgt;
          end else if (imem_ack) begin
            r_fetch_pc <= w_pc_plus4;
            r_addr     <= w_pc_plus4;
            if (w_count_next >= c_fb_depth) begin
              r_state <= S_IDLE;
              r_req   <= 1'b0;
            end
          end else if (redirect) begin
            // Request stays on the bus unchanged; its data is thrown away.
            r_fetch_pc <= w_tgt;
            r_state    <= S_DROP;
          end
        end
        S_DROP: begin
          if (redirect) r_fetch_pc <= w_tgt;
          if (imem_ack) begin
            r_state <= S_REQ;
            r_addr  <= redirect ? w_tgt : r_fetch_pc;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fb_instr[r_wr_ptr] <= imem_rdata;
      r_fb_pc4[r_wr_ptr]   <= w_pc_plus4;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_count <= w_count_next;
      if (redirect) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_bubble_cnt;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_fetch_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_pop) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (~if_valid & ~stall & ~redirect) r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign fetch_cnt  = r_fetch_cnt;
  assign bubble_cnt = r_bubble_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_if_fetch : randomized bench for if_fetch against a program-order model |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        clr_n = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] Instr;
  logic [31:0] pc4;
  logic        if_valid;
  logic        flush;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] bubble_cnt;
  logic [31:0] m_fetch = '0;
  logic [31:0] m_bubble = '0;
`endif

  int          n_checks = 0;
  int          n_err = 0;
  logic [31:0] exp_pc = 32'h0000_3000;
  int          lat_mode = 1;
  int          mem_wait = 0;
  int          mem_lat = 1;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          pops = 0;
  logic        found;

  if_fetch dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .Instr      (Instr),
    .pc4        (pc4),
    .if_valid   (if_valid),
    .flush      (flush)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt  (fetch_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Instruction memory contents: a distinct word per address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input logic st, input logic rd, input logic [31:0] tgt);
    logic p;
    if (if_valid) begin
      check("pc4", pc4, exp_pc + 32'd4);
      check("instr", Instr, mem_word(exp_pc));
    end else begin
      check("empty_instr", Instr, 32'd0);
      check("empty_pc4", pc4, 32'd0);
    end
    if (pend) begin
      check("req_hold", 32'(imem_req), 32'd1);
      check("addr_hold", imem_addr, pend_addr);
    end
    if (imem_req) check("addr_align", 32'(imem_addr[1:0]), 32'd0);
`ifdef IF_PERF_CNT_EN
    check("fetch_cnt", fetch_cnt, m_fetch);
    check("bubble_cnt", bubble_cnt, m_bubble);
`endif
    imem_ack = 1'b0;
    imem_rdata = $urandom;
    if (imem_req) begin
      if (mem_wait == 0) mem_lat = (lat_mode != 0) ? lat_mode : int'($urandom_range(1, 3));
      if (mem_wait + 1 >= mem_lat) begin
        imem_ack = 1'b1;
        mem_wait = 0;
      end else begin
        mem_wait++;
      end
      imem_rdata = mem_word(imem_addr);
    end
    stall = st;
    redirect = rd;
    redirect_pc = tgt;
    #1;
    check("flush", 32'(flush), 32'(rd));
    p = if_valid & !st & !rd;
`ifdef IF_PERF_CNT_EN
    if (p) m_fetch = m_fetch + 32'd1;
    if (!if_valid && !st && !rd) m_bubble = m_bubble + 32'd1;
`endif
    if (p) begin
      exp_pc = exp_pc + 32'd4;
      pops++;
    end
    if (rd) exp_pc = tgt & 32'hFFFF_FFFC;
    pend = imem_req & !imem_ack;
    pend_addr = imem_addr;
    @(negedge clk);
  endtask

  // Asynchronous reset in the low phase, then release; ends at the first post-reset falling edge.
  task automatic reset_dut();
    #2;
    imem_ack = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    clr_n = 1'b0;
    #1;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, 32'h0000_3000);
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_instr", Instr, 32'd0);
    check("rst_pc4", pc4, 32'd0);
    @(negedge clk);
    clr_n = 1'b1;
    exp_pc = 32'h0000_3000;
    mem_wait = 0;
    pend = 1'b0;
`ifdef IF_PERF_CNT_EN
    m_fetch = '0;
    m_bubble = '0;
`endif
    @(negedge clk);
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, 32'h0000_3000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] tgt;
    logic        st, rd;

    // Streaming with a single-cycle memory
    lat_mode = 1;
    reset_dut();
    for (int k = 0; k < 8; k++) begin
      check("seq_addr", imem_addr, 32'h0000_3000 + 32'(4 * k));
      step(1'b0, 1'b0, 32'd0);
    end

    // Stall fills the FIFO, request drops, then resumes without loss
    reset_dut();
    for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 32'd0);
    check("full_req_low", 32'(imem_req), 32'd0);
    check("full_valid", 32'(if_valid), 32'd1);
    check("full_head_pc4", pc4, 32'h0000_3004);
    found = 1'b0;
    for (int k = 0; k < 5 && !found; k++) begin
      step(1'b0, 1'b0, 32'd0);
      found = imem_req;
    end
    check("resume_seen", 32'(found), 32'd1);
    check("resume_addr", imem_addr, 32'h0000_3008);
    for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 32'd0);

    // Redirect while a slow fetch is pending
    reset_dut();
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (imem_req && imem_addr == 32'h0000_3010) found = 1'b1;
      else step(1'b0, 1'b0, 32'd0);
    end
    check("pend_3010_seen", 32'(found), 32'd1);
    lat_mode = 3;
    step(1'b0, 1'b1, 32'h0000_4000);
    check("drop_req", 32'(imem_req), 32'd1);
    check("drop_addr", imem_addr, 32'h0000_3010);
    step(1'b0, 1'b0, 32'd0);
    check("drop_addr2", imem_addr, 32'h0000_3010);
    step(1'b0, 1'b0, 32'd0);
    check("after_drop_req", 32'(imem_req), 32'd1);
    check("after_drop_addr", imem_addr, 32'h0000_4000);
    lat_mode = 1;
    found = 1'b0;
    for (int k = 0; k < 6 && !found; k++) begin
      step(1'b0, 1'b0, 32'd0);
      found = if_valid;
    end
    check("target_valid_seen", 32'(found), 32'd1);
    check("target_pc4", pc4, 32'h0000_4004);

    // Redirect coincident with ack and a non-empty FIFO
    reset_dut();
    step(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0);
    check("coinc_pre_valid", 32'(if_valid), 32'd1);
    step(1'b0, 1'b1, 32'h0000_4003);
    check("coinc_valid", 32'(if_valid), 32'd0);
    check("coinc_req", 32'(imem_req), 32'd1);
    check("coinc_addr", imem_addr, 32'h0000_4000);
    step(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0);

    // Reset in the middle of a request
    check("mid_req_pre", 32'(imem_req), 32'd1);
    reset_dut();

    // Randomized traffic: variable latency, stalls, redirects (incl. wrap and unaligned targets)
    lat_mode = 0;
    pops = 0;
    for (int k = 0; k < 2000; k++) begin
      st = ($urandom_range(0, 2) == 0);
      rd = ($urandom_range(0, 14) == 0);
      case ($urandom_range(0, 3))
        0:       tgt = $urandom;
        1:       tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: tgt = 32'h0000_3000 + 32'($urandom_range(0, 255) << 2);
      endcase
      step(st, rd, tgt);
    end
    check("rand_progress", 32'(pops > 200), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
